// File: rtl/ni_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : ni_packetizer
// Purpose  : Network-interface packetizer. Accepts a packet request
//            (destination + body length), emits one header flit followed by
//            1..16 body flits (PAYLOAD..., TAIL) into a downstream FIFO, and
//            counts completed packets.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            cur_addr_rst      - local node address, captured while rst=1
//            req_valid/ready   - request handshake; req_dst, req_len
//                                (req_len = body flits - 1)
//            data_valid/ready  - body word handshake; data_in (29 bit)
//            out_full          - downstream FIFO full
//            out_wr, flit_out  - flit write strobe and {flit_id, body}
//            busy              - not idle
//            pkt_cnt           - completed packet count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module ni_packetizer (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cur_addr_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_dst,
  input  logic [3:0]  req_len,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [28:0] data_in,
  input  logic        out_full,
  output logic        out_wr,
  output logic [31:0] flit_out,
  output logic        busy,
  output logic [7:0]  pkt_cnt
);

  // Flit type codes (one-hot)
  localparam logic [2:0] c_flit_header  = 3'b001;
  localparam logic [2:0] c_flit_payload = 3'b010;
  localparam logic [2:0] c_flit_tail    = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cur_addr;
  logic [3:0]  r_dst;
  logic [3:0]  r_len;
  logic [3:0]  r_cnt;
  logic [7:0]  r_pkt_cnt;

  logic        w_in_hdr;
  logic        w_in_body;
  logic        w_hdr_wr;
  logic        w_body_wr;
  logic        w_is_tail;

  // Every handshake/write output is qualified with ~rst so that the block is
  // silent for the whole reset window, including the cycle before the first
  // reset edge has cleared the state register.
  assign w_in_hdr  = (r_state == ST_HDR)  && !rst;
  assign w_in_body = (r_state == ST_BODY) && !rst;
  assign w_hdr_wr  = w_in_hdr && !out_full;
  assign w_body_wr = w_in_body && data_valid && !out_full;
  assign w_is_tail = (r_cnt == r_len);

  assign req_ready  = (r_state == ST_IDLE) && !rst;
  assign data_ready = w_in_body && !out_full;
  assign out_wr     = w_hdr_wr || w_body_wr;
  assign busy       = (r_state != ST_IDLE) && !rst;
  assign pkt_cnt    = r_pkt_cnt;

  // Body flits pass data_in straight through so a word is written on the same
  // edge it is consumed.
  always_comb begin
    flit_out = 32'h0;
    if (w_hdr_wr) begin
      flit_out = {c_flit_header, 9'h0, r_pkt_cnt, r_len, r_cur_addr, r_dst};
    end else if (w_body_wr) begin
      flit_out = {(w_is_tail ? c_flit_tail : c_flit_payload), data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_addr <= cur_addr_rst;
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_pkt_cnt  <= 8'd0;
      r_dst      <= 4'd0;
      r_len      <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_dst   <= req_dst;
            r_len   <= req_len;
            r_cnt   <= 4'd0;
            r_state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!out_full) begin
            r_state <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (w_body_wr) begin
            r_cnt <= r_cnt + 4'd1;
            if (w_is_tail) begin
              r_state   <= ST_IDLE;
              r_pkt_cnt <= r_pkt_cnt + 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ni_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ni_packetizer
// Purpose  : Self-checking bench for ni_packetizer. Expected flits are queued
//            when a request is issued and compared as the DUT writes them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ni_packetizer;

  localparam logic [2:0] c_hdr = 3'b001;
  localparam logic [2:0] c_pay = 3'b010;
  localparam logic [2:0] c_tl  = 3'b100;
  localparam logic [3:0] c_cur = 4'h5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  cur_addr_rst = 4'h0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_dst = 4'h0;
  logic [3:0]  req_len = 4'h0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [28:0] data_in = 29'h0;
  logic        out_full = 1'b0;
  logic        out_wr;
  logic [31:0] flit_out;
  logic        busy;
  logic [7:0]  pkt_cnt;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  m_cnt = 8'd0;

  ni_packetizer dut (
    .clk          (clk),
    .rst          (rst),
    .cur_addr_rst (cur_addr_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dst      (req_dst),
    .req_len      (req_len),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .data_in      (data_in),
    .out_full     (out_full),
    .out_wr       (out_wr),
    .flit_out     (flit_out),
    .busy         (busy),
    .pkt_cnt      (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hdr_flit(input logic [3:0] dst, input logic [3:0] len,
                                           input logic [7:0] seq);
    return {c_hdr, 9'h0, seq, len, c_cur, dst};
  endfunction

  // Scoreboard / protocol monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (out_full) begin
        chk("full_no_wr", {31'h0, out_wr}, 32'h0);
        chk("full_no_drdy", {31'h0, data_ready}, 32'h0);
      end
      if (out_wr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flit", flit_out, 32'hFFFF_FFFF);
        end else begin
          chk("flit", flit_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    cur_addr_rst = c_cur;
    rst = 1'b1;
    data_valid = 1'b1;   // must be ignored under reset
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_wr", {31'h0, out_wr}, 32'h0);
    chk("rst_flit", flit_out, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_data_ready", {31'h0, data_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_pkt_cnt", {24'h0, pkt_cnt}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_valid = 1'b0;
    cur_addr_rst = 4'hC; // must not be picked up outside reset
    exp_q.delete();
    m_cnt = 8'd0;
    #1;
    chk("idle_req_ready", {31'h0, req_ready}, 32'h1);
  endtask

  // Issues one packet with always-valid data; mask bit k drives out_full in
  // the k-th cycle after the request handshake. abort_after>=0 stops once
  // that many body words have been written.
  task automatic send_pkt(input logic [3:0] dst, input logic [3:0] len, input logic [28:0] base,
                          input logic [31:0] mask, input int abort_after, output int cycles);
    int  i;
    int  k;
    bit  got;
    exp_q.push_back(hdr_flit(dst, len, m_cnt));
    for (int j = 0; j <= int'(len); j++)
      exp_q.push_back({(j == int'(len)) ? c_tl : c_pay, base + 29'(j)});
    req_valid = 1'b1;
    req_dst   = dst;
    req_len   = len;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    req_dst   = 4'h0;
    req_len   = 4'h0;
    i = 0;
    k = 0;
    if (!got) chk("req_timeout", 32'h0, 32'h1);
    while (got && i <= int'(len) && k < 100) begin
      out_full   = (k < 32) ? mask[k] : 1'b0;
      data_valid = 1'b1;
      data_in    = base + 29'(i);
      @(negedge clk);
      chk("busy_in_pkt", {31'h0, busy}, 32'h1);
      chk("req_ready_in_pkt", {31'h0, req_ready}, 32'h0);
      if (data_valid && data_ready) i++;
      @(posedge clk);
      #1;
      k++;
      if (abort_after >= 0 && i == abort_after) break;
    end
    if (k >= 100) chk("body_timeout", 32'h0, 32'h1);
    data_valid = 1'b0;
    out_full   = 1'b0;
    data_in    = 29'h0;
    cycles     = k;
    if (abort_after < 0) m_cnt++;
  endtask

  task automatic post_pkt_checks(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_pkt_cnt"}, {24'h0, pkt_cnt}, {24'h0, m_cnt});
    chk({tag, "_q_empty"}, exp_q.size(), 32'h0);
  endtask

  initial begin
    int cyc;
    int hs;
    int dh;
    @(posedge clk);
    #1;
    do_reset();

    // Single-flit body: header 2000_005A, tail 8000_0001
    send_pkt(4'hA, 4'd0, 29'h1, 32'h0, -1, cyc);
    chk("t1_cycles", cyc, 32'd2);
    post_pkt_checks("t1");
    chk("t1_pkt_cnt_one", {24'h0, pkt_cnt}, 32'd1);

    // len=3 continuous: HDR + 4 body flits on 5 consecutive cycles
    send_pkt(4'h3, 4'd3, 29'h1, 32'h0, -1, cyc);
    chk("t2_cycles", cyc, 32'd5);
    post_pkt_checks("t2");

    // Counter restarts for a following packet
    send_pkt(4'h6, 4'd1, 29'h100, 32'h0, -1, cyc);
    chk("t3_cycles", cyc, 32'd3);
    post_pkt_checks("t3");

    // Backpressure: 3 cycles in HDR, 2 cycles between payload 1 and 2
    send_pkt(4'h9, 4'd3, 29'h0AB_C000, 32'h0000_00C7, -1, cyc);
    chk("t4_cycles", cyc, 32'd10);
    post_pkt_checks("t4");

    // Maximum length, local loopback destination
    send_pkt(c_cur, 4'd15, 29'h1FFF_FFF0, 32'h0, -1, cyc);
    chk("t5_cycles", cyc, 32'd17);
    post_pkt_checks("t5");

    // Abort after second PAYLOAD, remaining flits must never appear
    send_pkt(4'h2, 4'd3, 29'h40, 32'h0, 2, cyc);
    chk("t6_abort_cycles", cyc, 32'd3);
    do_reset();
    send_pkt(4'h7, 4'd0, 29'h55, 32'h0, -1, cyc);
    post_pkt_checks("t6_after_rst");

    // 256 back-to-back single-body loopback packets with req_valid held high
    do_reset();
    req_valid  = 1'b1;
    req_dst    = c_cur;
    req_len    = 4'd0;
    data_valid = 1'b1;
    data_in    = 29'h0;
    hs  = 0;
    dh  = 0;
    cyc = 0;
    for (int n = 0; n < 800 && dh < 256; n++) begin
      @(negedge clk);
      if (req_valid && req_ready) begin
        exp_q.push_back(hdr_flit(c_cur, 4'd0, m_cnt));
        exp_q.push_back({c_tl, 29'(hs)});
        m_cnt++;
        hs++;
      end
      if (data_valid && data_ready) dh++;
      @(posedge clk);
      #1;
      if (hs == 256) req_valid = 1'b0;
      if (dh == 256) data_valid = 1'b0;
      data_in = 29'(dh);
      cyc = n + 1;
    end
    req_valid  = 1'b0;
    data_valid = 1'b0;
    chk("b2b_requests", hs, 32'd256);
    chk("b2b_words", dh, 32'd256);
    chk("b2b_cycles", cyc, 32'd768);
    chk("b2b_wrap", {24'h0, pkt_cnt}, 32'h0);
    post_pkt_checks("b2b");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
